// File: rtl/q_pkg.sv
// Shared definitions for compare-and-swap pipelines: result pair layout and stage latency.
package q_pkg;

  localparam int CAS_W       = 32;
  localparam int CAS_TAG_W   = 4;
  localparam int CAS_LATENCY = 2;

  typedef struct packed {
    logic [CAS_W-1:0]     lo;
    logic [CAS_W-1:0]     hi;
    logic                 swp;
    logic                 eq;
    logic [CAS_TAG_W-1:0] tag;
  } cas_pair_t;

endpackage

// File: rtl/cas_pipe_cmp.sv
// cmp: purely combinational magnitude comparator, signed or unsigned by parameter.
module cmp #(
  parameter int W         = 32,
  parameter bit IS_SIGNED = 1'b1
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_lt,
  output logic         o_eq,
  output logic         o_gt
);

  generate
    if (IS_SIGNED) begin : g_signed
      assign o_lt = $signed(i_a) < $signed(i_b);
      assign o_gt = $signed(i_a) > $signed(i_b);
    end else begin : g_unsigned
      assign o_lt = i_a < i_b;
      assign o_gt = i_a > i_b;
    end
  endgenerate

  assign o_eq = (i_a == i_b);

endmodule

// File: rtl/cas_pipe.sv
// cas_pipe: two-stage valid/ready compare-and-swap; 2-cycle latency, 1 pair/cycle.
// Optional saturating swap counter built when CAS_PIPE_SWP_CNT_EN is defined.
module cas_pipe
  import q_pkg::*;
#(
  parameter int W          = 32,
  parameter bit IS_SIGNED  = 1'b1,
  parameter bit DESCENDING = 1'b0,
  parameter int TAG_W      = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             i_in_vld,
  input  logic [W-1:0]     i_in_a,
  input  logic [W-1:0]     i_in_b,
  input  logic [TAG_W-1:0] i_in_tag,
  output logic             o_in_rdy,
  output logic             o_out_vld,
  output logic [W-1:0]     o_out_lo,
  output logic [W-1:0]     o_out_hi,
  output logic             o_out_swp,
  output logic             o_out_eq,
  output logic [TAG_W-1:0] o_out_tag,
  input  logic             i_out_rdy,
  output logic [CNT_W-1:0] o_swp_cnt,
  input  logic             i_swp_cnt_clr
);

  typedef struct packed {
    logic [W-1:0]     lo;
    logic [W-1:0]     hi;
    logic             swp;
    logic             eq;
    logic [TAG_W-1:0] tag;
  } pair_t;

  logic             r_s1_vld;
  logic [W-1:0]     r_s1_a;
  logic [W-1:0]     r_s1_b;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_out_vld;
  pair_t            r_out;

  logic  w_lt, w_eq, w_gt, w_swp, w_s2_adv;
  pair_t w_pair;

  cmp #(.W(W), .IS_SIGNED(IS_SIGNED)) u_cmp (
    .i_a  (r_s1_a),
    .i_b  (r_s1_b),
    .o_lt (w_lt),
    .o_eq (w_eq),
    .o_gt (w_gt)
  );

  // Strict comparisons only, so equal operands keep their input order.
  assign w_swp = DESCENDING ? w_lt : w_gt;

  always_comb begin
    w_pair     = '0;
    w_pair.lo  = w_swp ? r_s1_b : r_s1_a;
    w_pair.hi  = w_swp ? r_s1_a : r_s1_b;
    w_pair.swp = w_swp;
    w_pair.eq  = w_eq;
    w_pair.tag = r_s1_tag;
  end

  assign w_s2_adv = ~r_out_vld | i_out_rdy;
  assign o_in_rdy = ~r_s1_vld | w_s2_adv;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_tag <= '0;
    end else if (o_in_rdy) begin
      r_s1_vld <= i_in_vld;
      if (i_in_vld) begin
        r_s1_a   <= i_in_a;
        r_s1_b   <= i_in_b;
        r_s1_tag <= i_in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_out_vld <= 1'b0;
      r_out     <= '0;
    end else if (w_s2_adv) begin
      r_out_vld <= r_s1_vld;
      if (r_s1_vld) r_out <= w_pair;
    end
  end

  assign o_out_vld = r_out_vld;
  assign o_out_lo  = r_out.lo;
  assign o_out_hi  = r_out.hi;
  assign o_out_swp = r_out.swp;
  assign o_out_eq  = r_out.eq;
  assign o_out_tag = r_out.tag;

`ifdef CAS_PIPE_SWP_CNT_EN
  logic [CNT_W-1:0] r_swp_cnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_swp_cnt <= '0;
    end else if (i_swp_cnt_clr) begin
      r_swp_cnt <= '0;
    end else if (r_out_vld && i_out_rdy && r_out.swp && (r_swp_cnt != {CNT_W{1'b1}})) begin
      r_swp_cnt <= r_swp_cnt + 1'b1;
    end
  end

  assign o_swp_cnt = r_swp_cnt;
`else
  logic w_unused_clr;
  assign w_unused_clr = i_swp_cnt_clr;
  assign o_swp_cnt    = '0;
`endif

endmodule

// File: tb/tb_cas_pipe.sv
// Bench for cas_pipe: three W=8 instances (signed asc, unsigned asc, signed desc) share one stimulus.
module tb_cas_pipe;

  localparam int W = 8;
  localparam int TW = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          i_in_vld = 1'b0;
  logic [W-1:0]  i_in_a = '0, i_in_b = '0;
  logic [TW-1:0] i_in_tag = '0;
  logic          i_out_rdy = 1'b1;
  logic          i_swp_cnt_clr = 1'b0;

  logic          s_rdy, s_vld, s_swp, s_eq;
  logic [W-1:0]  s_lo, s_hi;
  logic [TW-1:0] s_tag;
  logic [CW-1:0] s_cnt;
  logic          u_rdy, u_vld, u_swp, u_eq;
  logic [W-1:0]  u_lo, u_hi;
  logic [TW-1:0] u_tag;
  logic [CW-1:0] u_cnt;
  logic          d_rdy, d_vld, d_swp, d_eq;
  logic [W-1:0]  d_lo, d_hi;
  logic [TW-1:0] d_tag;
  logic [CW-1:0] d_cnt;

  always #5 clk = ~clk;

  cas_pipe #(.W(W), .IS_SIGNED(1'b1), .DESCENDING(1'b0), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .arst_n(arst_n), .i_in_vld(i_in_vld), .i_in_a(i_in_a), .i_in_b(i_in_b),
    .i_in_tag(i_in_tag), .o_in_rdy(s_rdy), .o_out_vld(s_vld), .o_out_lo(s_lo), .o_out_hi(s_hi),
    .o_out_swp(s_swp), .o_out_eq(s_eq), .o_out_tag(s_tag), .i_out_rdy(i_out_rdy),
    .o_swp_cnt(s_cnt), .i_swp_cnt_clr(i_swp_cnt_clr));

  cas_pipe #(.W(W), .IS_SIGNED(1'b0), .DESCENDING(1'b0), .TAG_W(TW), .CNT_W(CW)) dut_u (
    .clk(clk), .arst_n(arst_n), .i_in_vld(i_in_vld), .i_in_a(i_in_a), .i_in_b(i_in_b),
    .i_in_tag(i_in_tag), .o_in_rdy(u_rdy), .o_out_vld(u_vld), .o_out_lo(u_lo), .o_out_hi(u_hi),
    .o_out_swp(u_swp), .o_out_eq(u_eq), .o_out_tag(u_tag), .i_out_rdy(i_out_rdy),
    .o_swp_cnt(u_cnt), .i_swp_cnt_clr(i_swp_cnt_clr));

  cas_pipe #(.W(W), .IS_SIGNED(1'b1), .DESCENDING(1'b1), .TAG_W(TW), .CNT_W(CW)) dut_d (
    .clk(clk), .arst_n(arst_n), .i_in_vld(i_in_vld), .i_in_a(i_in_a), .i_in_b(i_in_b),
    .i_in_tag(i_in_tag), .o_in_rdy(d_rdy), .o_out_vld(d_vld), .o_out_lo(d_lo), .o_out_hi(d_hi),
    .o_out_swp(d_swp), .o_out_eq(d_eq), .o_out_tag(d_tag), .i_out_rdy(i_out_rdy),
    .o_swp_cnt(d_cnt), .i_swp_cnt_clr(i_swp_cnt_clr));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One record: inputs, then {lo, hi, swp} expected from each of the three instances.
  typedef struct {
    logic [W-1:0]  a, b;
    logic [TW-1:0] tag;
    logic [W-1:0]  s_lo, s_hi; logic s_swp;
    logic [W-1:0]  u_lo, u_hi; logic u_swp;
    logic [W-1:0]  d_lo, d_hi; logic d_swp;
    logic          eq;
  } vec_t;

  typedef struct packed {
    logic [W-1:0]  lo, hi;
    logic          swp, eq;
    logic [TW-1:0] tag;
  } exp_t;

  vec_t vecs[6];
  exp_t exp_q[$];

  task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] t);
    @(negedge clk);
    i_in_vld = 1'b1; i_in_a = a; i_in_b = b; i_in_tag = t;
    @(negedge clk);
    i_in_vld = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h05, 8'h03, 4'h1, 8'h03, 8'h05, 1'b1, 8'h03, 8'h05, 1'b1, 8'h05, 8'h03, 1'b0, 1'b0};
    vecs[1] = '{8'h7F, 8'h80, 4'h2, 8'h80, 8'h7F, 1'b1, 8'h7F, 8'h80, 1'b0, 8'h7F, 8'h80, 1'b0, 1'b0};
    vecs[2] = '{8'h42, 8'h42, 4'hA, 8'h42, 8'h42, 1'b0, 8'h42, 8'h42, 1'b0, 8'h42, 8'h42, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 8'h01, 4'h3, 8'hFF, 8'h01, 1'b0, 8'h01, 8'hFF, 1'b1, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 4'hF, 8'h80, 8'h80, 1'b0, 8'h80, 8'h80, 1'b0, 8'h80, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'h10, 8'h20, 4'h0, 8'h10, 8'h20, 1'b0, 8'h10, 8'h20, 1'b0, 8'h20, 8'h10, 1'b1, 1'b0};

    // Reset state
    #1;
    chk("rst_vld", {31'd0, s_vld}, 0);
    chk("rst_data", {13'd0, s_lo, s_hi, s_swp, s_eq, s_tag}, 0);
    chk("rst_cnt", {30'd0, s_cnt}, 0);
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    #1 chk("rst_in_rdy", {31'd0, s_rdy}, 1);

    // Directed table: isolated pairs, latency and ordering on all three instances
    foreach (vecs[i]) begin
      @(negedge clk);
      i_in_vld = 1'b1; i_in_a = vecs[i].a; i_in_b = vecs[i].b; i_in_tag = vecs[i].tag;
      @(negedge clk);
      i_in_vld = 1'b0;
      #1 chk($sformatf("v%0d_vld_c1", i), {31'd0, s_vld}, 0);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_vld_c2", i), {29'd0, s_vld, u_vld, d_vld}, 3'b111);
      chk($sformatf("v%0d_s", i), {15'd0, s_lo, s_hi, s_swp}, {15'd0, vecs[i].s_lo, vecs[i].s_hi, vecs[i].s_swp});
      chk($sformatf("v%0d_u", i), {15'd0, u_lo, u_hi, u_swp}, {15'd0, vecs[i].u_lo, vecs[i].u_hi, vecs[i].u_swp});
      chk($sformatf("v%0d_d", i), {15'd0, d_lo, d_hi, d_swp}, {15'd0, vecs[i].d_lo, vecs[i].d_hi, vecs[i].d_swp});
      chk($sformatf("v%0d_eq", i), {29'd0, s_eq, u_eq, d_eq}, {29'd0, {3{vecs[i].eq}}});
      chk($sformatf("v%0d_tag", i), {20'd0, s_tag, u_tag, d_tag}, {20'd0, {3{vecs[i].tag}}});
    end

    // Backpressure stream: 8 back-to-back pairs, random i_out_rdy
    begin
      int sent = 0, got = 0, occ = 0;
      logic stalled = 1'b0;
      logic [W+W+TW+2:0] held = '0;
      logic [W+W+TW+2:0] cur;
      logic [W-1:0] a, b;
      logic hs_in, hs_out;
      exp_t e, g;
      for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
        @(negedge clk);
        i_out_rdy = 1'($urandom_range(0, 1));
        if (sent < 8) begin
          a = 8'(sent * 37 + 11); b = 8'(sent * 91 + 5);
          i_in_vld = 1'b1; i_in_a = a; i_in_b = b; i_in_tag = 4'(sent);
        end else begin
          i_in_vld = 1'b0;
        end
        #1;
        cur = {s_vld, s_lo, s_hi, s_swp, s_eq, s_tag};
        if (stalled) chk("bp_hold", 32'(cur), 32'(held));
        chk("bp_in_rdy", {31'd0, s_rdy}, {31'd0, !(occ == 2 && !i_out_rdy)});
        hs_in  = i_in_vld & s_rdy;
        hs_out = s_vld & i_out_rdy;
        if (hs_out) begin
          g = '{s_lo, s_hi, s_swp, s_eq, s_tag};
          e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          chk($sformatf("bp_out%0d", got), 32'(g), 32'(e));
          got++; occ--;
        end
        if (hs_in) begin
          e.swp = ($signed(i_in_a) > $signed(i_in_b));
          e.lo  = e.swp ? i_in_b : i_in_a;
          e.hi  = e.swp ? i_in_a : i_in_b;
          e.eq  = (i_in_a == i_in_b);
          e.tag = i_in_tag;
          exp_q.push_back(e);
          sent++; occ++;
        end
        stalled = s_vld & ~i_out_rdy;
        held = cur;
      end
      i_in_vld = 1'b0;
      chk("bp_count", got, 8);
    end

    // Reset with two pairs in flight
    @(negedge clk);
    i_out_rdy = 1'b0;
    i_in_vld = 1'b1; i_in_a = 8'h11; i_in_b = 8'h22; i_in_tag = 4'h5;
    @(negedge clk);
    i_in_a = 8'h33; i_in_b = 8'h01; i_in_tag = 4'h6;
    @(negedge clk);
    i_in_vld = 1'b0;
    #1 chk("full_in_rdy", {31'd0, s_rdy}, 0);
    arst_n = 1'b0;
    #1 chk("arst_vld", {29'd0, s_vld, u_vld, d_vld}, 0);
    chk("arst_lo", {24'd0, s_lo}, 0);
    @(negedge clk);
    arst_n = 1'b1; i_out_rdy = 1'b1;
    begin
      int bad = 0;
      repeat (4) begin
        @(negedge clk);
        #1 if (s_vld) bad++;
      end
      chk("post_rst_quiet", bad, 0);
    end
    send_one(8'h09, 8'h02, 4'h7);
    #1 chk("post_rst_c1", {31'd0, s_vld}, 0);
    @(negedge clk);
    #1 chk("post_rst_c2", {1'b0, s_vld, s_lo, s_hi, s_swp, s_eq, s_tag, 9'd0},
           {1'b0, 1'b1, 8'h02, 8'h09, 1'b1, 1'b0, 4'h7, 9'd0});

`ifdef CAS_PIPE_SWP_CNT_EN
    @(negedge clk);
    i_swp_cnt_clr = 1'b1;
    @(negedge clk);
    i_swp_cnt_clr = 1'b0;
    #1 chk("cnt_clr", {30'd0, s_cnt}, 0);
    for (int k = 0; k < 5; k++) begin
      i_in_vld = 1'b1; i_in_a = 8'h05; i_in_b = 8'h03; i_in_tag = 4'(k);
      @(negedge clk);
    end
    i_in_vld = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("cnt_sat", {30'd0, s_cnt}, 3);
    send_one(8'h05, 8'h03, 4'h1);
    @(negedge clk);
    i_swp_cnt_clr = 1'b1;
    #1 chk("clr_hs_vld", {31'd0, s_vld}, 1);
    @(negedge clk);
    i_swp_cnt_clr = 1'b0;
    #1 chk("cnt_clr_wins", {30'd0, s_cnt}, 0);
    send_one(8'h05, 8'h03, 4'h2);
    repeat (2) @(negedge clk);
    #1 chk("cnt_one", {30'd0, s_cnt}, 1);
`else
    @(negedge clk);
    #1 chk("cnt_tied", {30'd0, s_cnt}, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
